// File: rtl/axi_mem_write_slave_if.sv
// Write-path bus bundle (AW, W, B channels) shared by the AXI master driver
// and the memory write slave.
interface axi_mem_write_slave_if #(
  parameter int ID_W = 4
);
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] awid;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [31:0]     awaddr;
  logic [1:0]      awburst;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport slave (
    input  awvalid, awid, awlen, awsize, awaddr, awburst,
    input  wvalid, wid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );

  modport master (
    output awvalid, awid, awlen, awsize, awaddr, awburst,
    output wvalid, wid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_mem_write_slave.sv
// AXI3-style write slave: one burst at a time into a strobed word memory, B response,
// registered backdoor read. Define AXI_MEM_WRAP_BURST_EN to accept WRAP bursts.
module axi_mem_write_slave #(
  parameter int MEM_DEPTH = 128,
  parameter int ID_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_mem_write_slave_if.slave        bus,
  input  logic [31:0]                 dbg_addr,
  output logic [31:0]                 dbg_rdata
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t          r_state;
  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp;
  logic            r_err;
  logic [3:0]      r_cnt;

  logic [ID_W-1:0] r_id;
  logic [31:0]     r_start;
  logic [31:0]     r_addr;
  logic [3:0]      r_len;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;

  logic [31:0]     r_mem [MEM_DEPTH];
  logic [31:0]     r_dbg_rdata;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_last_beat;
  logic            w_wrap_err;
  logic            w_cfg_err;
  logic            w_beat_err;
  logic            w_we;
  logic [31:0]     w_word;
  logic            w_in_range;
  logic [31:0]     w_dbg_word;
  logic            w_dbg_in_range;
  logic [31:0]     w_next_addr;

  // WRAP keeps the address inside a (len+1)<<size container aligned down from the start.
  function automatic logic [31:0] f_next_addr(input logic [31:0] addr,
                                              input logic [31:0] start,
                                              input logic [3:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
    logic [31:0] incr;
    logic [31:0] span;
    logic [31:0] nxt;
    incr = 32'(1) << size;
    span = (32'(len) + 32'd1) << size;
    nxt  = addr + incr;
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (start & ~(span - 32'd1)) | (nxt & (span - 32'd1));
      default: f_next_addr = nxt;
    endcase
  endfunction

  assign w_aw_hs     = (r_state == S_IDLE) && r_awready && bus.awvalid;
  assign w_w_hs      = (r_state == S_DATA) && r_wready && bus.wvalid;
  assign w_last_beat = (r_cnt == r_len);

`ifdef AXI_MEM_WRAP_BURST_EN
  assign w_wrap_err = (r_burst == 2'b10) &&
                      (!((r_len == 4'd1) || (r_len == 4'd3) || (r_len == 4'd7) || (r_len == 4'd15)) ||
                       ((r_start & ((32'(1) << r_size) - 32'd1)) != 32'd0));
`else
  assign w_wrap_err = (r_burst == 2'b10);
`endif

  assign w_cfg_err   = (r_size > 3'd2) || (r_burst == 2'b11) || w_wrap_err;
  assign w_word      = r_addr >> 2;
  assign w_in_range  = (w_word < 32'(MEM_DEPTH));
  assign w_beat_err  = w_cfg_err || !w_in_range || (bus.wid != r_id) ||
                       (bus.wlast != w_last_beat);
  assign w_we        = w_w_hs && !r_err && !w_beat_err;
  assign w_next_addr = f_next_addr(r_addr, r_start, r_len, r_size, r_burst);

  assign w_dbg_word     = dbg_addr >> 2;
  assign w_dbg_in_range = (w_dbg_word < 32'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_state   <= S_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_beat_err) r_err <= 1'b1;
            // Beat count alone closes the burst; a misplaced wlast only flags the error.
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_beat_err) ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (r_bvalid && bus.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_id    <= bus.awid;
      r_start <= bus.awaddr;
      r_addr  <= bus.awaddr;
      r_len   <= bus.awlen;
      r_size  <= bus.awsize;
      r_burst <= bus.awburst;
    end else if (w_w_hs) begin
      r_addr  <= w_next_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) r_mem[w_word[IDX_W-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_rdata <= '0;
    end else begin
      r_dbg_rdata <= w_dbg_in_range ? r_mem[w_dbg_word[IDX_W-1:0]] : 32'd0;
    end
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bid     = r_bid;
  assign bus.bresp   = r_bresp;
  assign dbg_rdata   = r_dbg_rdata;
endmodule

// File: tb/tb_axi_mem_write_slave.sv
// Directed bench for axi_mem_write_slave: reset, INCR/FIXED/WRAP bursts, strobes,
// protocol and range errors, B back-pressure and mid-burst reset.
module tb_axi_mem_write_slave;
  logic        clk;
  logic        rst;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_rdata;
  int          n_vec;
  int          n_miss;

  axi_mem_write_slave_if #(.ID_W(4)) bus ();

  axi_mem_write_slave #(.MEM_DEPTH(128), .ID_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.awready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.awvalid = 1'b0;
    if (!ok) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] id);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wid = id;
    bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.wready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.wvalid = 1'b0;
    if (!ok) chk("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp,
                       input int hold);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.bvalid === 1'b1) ok = 1'b1;
    end
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_bvalid_held"}, 32'(bus.bvalid), 32'd1);
      chk({tag, "_bid_held"}, 32'(bus.bid), 32'(exp_id));
    end
    chk({tag, "_bid"}, 32'(bus.bid), 32'(exp_id));
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
    bus.bready = 1'b1;
    @(posedge clk);
    #1 bus.bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
    chk({tag, "_awready_back"}, 32'(bus.awready), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = addr;
    @(posedge clk);
    #1 chk(tag, dbg_rdata, exp);
  endtask

  task automatic preload(input logic [31:0] addr, input int n, input logic [31:0] val);
    send_aw(4'd0, addr, 4'(n - 1), 3'd2, 2'b01);
    for (int i = 0; i < n; i++) send_w(val, 4'hF, (i == n - 1), 4'd0);
    get_b("preload", 4'd0, 2'b00, 0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; dbg_addr = 32'd0;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awaddr = '0;
    bus.awburst = '0; bus.wvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.wlast = 1'b0; bus.bready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_dbg", dbg_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_awready", 32'(bus.awready), 32'd1);

    // INCR 4 beats with B back-pressure
    send_aw(4'd5, 32'h10, 4'd3, 3'd2, 2'b01);
    chk("incr_wready_up", 32'(bus.wready), 32'd1);
    chk("incr_awready_low", 32'(bus.awready), 32'd0);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), 4'hF, (i == 3), 4'd5);
    chk("incr_wready_down", 32'(bus.wready), 32'd0);
    get_b("incr", 4'd5, 2'b00, 5);
    for (int i = 0; i < 4; i++) rd("incr_word", 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));

    // FIXED single beat with partial strobes
    preload(32'h0, 1, 32'hFFFF_FFFF);
    send_aw(4'd1, 32'h0, 4'd0, 3'd2, 2'b00);
    send_w(32'h1234_5678, 4'b0101, 1'b1, 4'd1);
    get_b("fixed", 4'd1, 2'b00, 0);
    rd("fixed_word0", 32'h0, 32'hFF34_FF78);

    // Early wlast: all four beats consumed, only beat 0 written
    preload(32'h40, 4, 32'h1111_1111);
    send_aw(4'd2, 32'h40, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hB0 + 32'(i), 4'hF, (i == 1), 4'd2);
    get_b("early_wlast", 4'd2, 2'b10, 0);
    rd("early_w16", 32'h40, 32'hB0);
    rd("early_w17", 32'h44, 32'h1111_1111);
    rd("early_w18", 32'h48, 32'h1111_1111);
    rd("early_w19", 32'h4C, 32'h1111_1111);

    // wid mismatch leaves word 4 untouched
    send_aw(4'd3, 32'h10, 4'd0, 3'd2, 2'b01);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b1, 4'd4);
    get_b("wid_err", 4'd3, 2'b10, 0);
    rd("wid_err_w4", 32'h10, 32'hA0);

    // Out-of-range word 128 must not alias onto word 0
    send_aw(4'd6, 32'h200, 4'd0, 3'd2, 2'b01);
    send_w(32'h9999_9999, 4'hF, 1'b1, 4'd6);
    get_b("oor", 4'd6, 2'b10, 0);
    rd("oor_dbg", 32'h200, 32'd0);
    rd("oor_w0", 32'h0, 32'hFF34_FF78);

    // WRAP from 0x0C over a 16-byte container
    preload(32'h0, 4, 32'h2222_2222);
    send_aw(4'd7, 32'h0C, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) send_w(32'hC0 + 32'(i), 4'hF, (i == 3), 4'd7);
`ifdef AXI_MEM_WRAP_BURST_EN
    get_b("wrap", 4'd7, 2'b00, 0);
    rd("wrap_w3", 32'h0C, 32'hC0);
    rd("wrap_w0", 32'h00, 32'hC1);
    rd("wrap_w1", 32'h04, 32'hC2);
    rd("wrap_w2", 32'h08, 32'hC3);
`else
    get_b("wrap", 4'd7, 2'b10, 0);
    rd("wrap_w3", 32'h0C, 32'h2222_2222);
    rd("wrap_w0", 32'h00, 32'h2222_2222);
    rd("wrap_w1", 32'h04, 32'h2222_2222);
    rd("wrap_w2", 32'h08, 32'h2222_2222);
`endif

    // Mid-burst reset keeps already written beats
    send_aw(4'd8, 32'h60, 4'd3, 3'd2, 2'b01);
    send_w(32'h5555_5555, 4'hF, 1'b0, 4'd8);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_awready", 32'(bus.awready), 32'd0);
    chk("midrst_wready", 32'(bus.wready), 32'd0);
    chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("midrst_awready_back", 32'(bus.awready), 32'd1);
    rd("midrst_w24", 32'h60, 32'h5555_5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
